// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer
//   In-order FIFO between the fetch stage (program counter + instruction
//   memory) and decode. It captures {pc, instr} pairs, presents the head
//   entry to decode with a valid/ready handshake, and throttles the PC
//   register through pc_en. A redirect (flush) empties the buffer.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      redirect: drop all buffered and same-cycle entries
//   in_valid   fetch stage offers {in_pc, in_instr}
//   in_pc      PC of the fetched instruction
//   in_instr   fetched instruction word
//   pc_en      program counter may advance (buffer not full)
//   out_valid  head entry valid for decode
//   out_pc     PC of head entry (0 when empty)
//   out_instr  instruction of head entry (NOP when empty)
//   out_ready  decode accepts the head entry
//   count      current occupancy
module if_fetch_buffer #(
  parameter int unsigned       DEPTH = 4,
  parameter int unsigned       AW    = 32,
  parameter int unsigned       IW    = 32,
  parameter logic [IW-1:0]     NOP   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [AW-1:0]              in_pc,
  input  logic [IW-1:0]              in_instr,
  output logic                       pc_en,
  output logic                       out_valid,
  output logic [AW-1:0]              out_pc,
  output logic [IW-1:0]              out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] pc_mem_q    [DEPTH];
  logic [IW-1:0] instr_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic push;
  logic pop;

  // pc_en depends on registered occupancy only; a pop while full does not
  // open a slot in the same cycle.
  assign pc_en     = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid  & pc_en     & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : NOP;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= in_instr;
    end
  end

endmodule

// File: tb/tb_if_fetch_buffer.sv
module tb_if_fetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned IW    = 32;
  localparam logic [31:0] NOPV  = 32'h00000013;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [AW-1:0] in_pc;
  logic [IW-1:0] in_instr;
  logic          pc_en;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_instr;
  logic          out_ready;
  logic [2:0]    count;

  if_fetch_buffer #(.DEPTH(DEPTH), .AW(AW), .IW(IW), .NOP(NOPV)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .pc_en(pc_en), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_ready(out_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer contents as an ordered list of pairs.
  logic [63:0] exp_q [$];

  // Stimulus issued in the current cycle, committed to the model after the edge.
  logic        pend_push  = 1'b0;
  logic        pend_flush = 1'b0;
  logic [63:0] pend_item  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs with model head, consume on handshake.
  always @(negedge clk) begin
    int unsigned n;
    n = exp_q.size();
    chk("count", 64'(count), 64'(n));
    chk("count_le_depth", 64'(count <= 3'(DEPTH)), 64'd1);
    chk("out_valid", 64'(out_valid), 64'(n != 0));
    chk("pc_en", 64'(pc_en), 64'(n != DEPTH));
    if (n != 0) begin
      chk("out_pc", 64'(out_pc), 64'(exp_q[0][63:32]));
      chk("out_instr", 64'(out_instr), 64'(exp_q[0][31:0]));
      if (reset && out_ready && !flush) void'(exp_q.pop_front());
    end else begin
      chk("empty_pc", 64'(out_pc), 64'd0);
      chk("empty_instr", 64'(out_instr), 64'(NOPV));
    end
  end

  // One clock of stimulus: commit last cycle's effects, then drive new inputs.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    if (pend_flush) exp_q.delete();
    else if (pend_push) exp_q.push_back(pend_item);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    pend_flush = fl;
    pend_push  = v && !fl && (exp_q.size() != DEPTH);
    pend_item  = {pc, ins};
  endtask

  task automatic idle(input int unsigned n, input logic rdy);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, '0, '0, rdy, 1'b0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_pc = '0; in_instr = '0; out_ready = 1'b0;

    // Reset / idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'(NOPV));
    chk("rst_pc_en", 64'(pc_en), 64'd1);
    chk("rst_count", 64'(count), 64'd0);

    // Streaming with out_ready high
    cycle(1'b1, 32'h0, 32'h00500093, 1'b1, 1'b0);
    cycle(1'b1, 32'h4, 32'h00a00113, 1'b1, 1'b0);
    cycle(1'b1, 32'h8, 32'h002081b3, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Fill and backpressure; 5th PC must not be stored
    for (int unsigned i = 0; i < 5; i++)
      cycle(1'b1, 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // Wrap-around with out_ready toggling
    for (int unsigned i = 0; i < 10; i++)
      cycle(1'b1, 32'h200 + 32'(4 * i), 32'h2000 + 32'(i), ((i % 2) == 0), 1'b0);
    idle(8, 1'b1);

    // Flush with count=3, same-cycle push and pop dropped
    for (int unsigned i = 0; i < 3; i++)
      cycle(1'b1, 32'h40 + 32'(4 * i), 32'h3000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b1, 32'h20, 32'hdeadbeef, 1'b1, 1'b1);
    cycle(1'b1, 32'h100, 32'h00000073, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Asynchronous reset mid-stream
    cycle(1'b1, 32'h300, 32'h4000, 1'b0, 1'b0);
    cycle(1'b1, 32'h304, 32'h4001, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_pc_en", 64'(pc_en), 64'd1);
    chk("arst_out_instr", 64'(out_instr), 64'(NOPV));
    chk("arst_out_pc", 64'(out_pc), 64'd0);
    exp_q.delete();
    pend_push = 1'b0;
    pend_flush = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;

    // Randomized traffic
    for (int unsigned i = 0; i < 400; i++)
      cycle(($urandom % 4) != 0, $urandom & 32'hfffffffc, $urandom,
            ($urandom % 3) != 0, ($urandom % 25) == 0);
    idle(8, 1'b1);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
- Consumer end of the fetch address path. Captures each {PC, instruction} pair produced by the PC register and instruction memory.
- Buffers the pairs in a small in-order FIFO and presents them to decode with a valid/ready handshake.
- Drives the PC register enable as backpressure, so the PC only advances while the buffer has space.
- Sits between the IF stage (program_counter + instruction memory) and the IF/ID boundary. Branch/jump redirect flushes it.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
AW, 32, PC/address width
IW, 32, instruction width
NOP, 32'h00000013, instruction presented on out_instr when empty (addi x0,x0,0)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset
flush  input  1  redirect from EX (taken branch/jump); discards all buffered and incoming entries
in_valid  input  1  IF has a valid {in_pc, in_instr} this cycle
in_pc  input  AW  PC of the fetched instruction (program_counter count)
in_instr  input  IW  fetched instruction word
pc_en  output  1  enable to program_counter; high = PC may advance
out_valid  output  1  head entry valid for decode
out_pc  output  AW  PC of head entry
out_instr  output  IW  instruction of head entry
out_ready  input  1  decode accepts head (low = load-use stall)
count  output  log2(DEPTH)+1  current occupancy, for hazard unit and debug

Behaviour:
- Storage: DEPTH x (AW+IW) array, wr_ptr/rd_ptr of log2(DEPTH) bits. Pointers wrap modulo DEPTH; the occupancy register is separate.
- Reset (reset=0, async, immediate): wr_ptr=0, rd_ptr=0, count=0. Outputs: out_valid=0, out_pc=0, out_instr=NOP, pc_en=1. Array contents are don't-care.
- push = in_valid & pc_en & ~flush. pop = out_valid & out_ready & ~flush.
- pc_en = (count != DEPTH). It is a registered-state function only, with no combinational path from out_ready. When full, a same-cycle pop does not enable a push; this one-cycle bubble is accepted.
- Push at clock edge: array[wr_ptr] <= {in_pc, in_instr}, wr_ptr += 1.
- Pop at clock edge: rd_ptr += 1.
- count update: push only +1; pop only -1; both: unchanged; neither: unchanged.
- Simultaneous push and pop at count=1: the new entry is written while the head is consumed. Next cycle count=1 and the head is the new entry.
- Output read is combinational from array[rd_ptr]; data is visible the cycle after push (one-cycle latency IF -> decode).
- out_valid = (count != 0). When empty: out_pc=0, out_instr=NOP.
- Entries leave in push order; no reordering, no duplication, no loss except on flush.
- flush=1 (synchronous, highest priority):
  - Next cycle wr_ptr=0, rd_ptr=0, count=0.
  - The same-cycle in_valid entry is dropped and the same-cycle pop does not occur.
  - pc_en is 1 in the cycle after flush. The redirected PC loads via the program_counter path, which the hazard unit ORs with the redirect.
- flush with reset=0: reset wins.
- Reset asserted mid-stream: all entries lost immediately; outputs take reset values within the same cycle, without waiting for a clock edge.
- in_valid while pc_en=0: ignored. IF must hold the same PC because program_counter is not enabled.
- Overflow/underflow cannot occur by construction. The bench asserts count never exceeds DEPTH and never wraps below 0.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, release -> out_valid=0, out_instr=32'h00000013, pc_en=1, count=0.
- Streaming, out_ready=1:
  - Push PCs 0x0,0x4,0x8 with instrs 0x00500093,0x00a00113,0x002081b3 on consecutive cycles -> same pairs appear on out_* one cycle after each push, in order.
  - count stays at 1 throughout and pc_en stays 1.
- Fill/backpressure:
  - out_ready=0, in_valid=1, PCs 0x0..0xC -> count reaches 4 and pc_en=0.
  - A 5th offered PC 0x10 is not stored.
  - Raise out_ready -> pops return 0x0,0x4,0x8,0xC in order; pc_en re-asserts once count=3.
- Wrap-around: run 10 push/pop cycles with out_ready toggling 1,0,1,0 -> output sequence equals input sequence exactly; pointers wrap past 3 with no loss.
- Flush:
  - With count=3, assert flush together with in_valid (PC 0x20) and out_ready=1 -> next cycle count=0, out_valid=0, pc_en=1.
  - PC 0x20 is never output, and the first post-flush push (PC 0x100) is the next out_pc.
- Async reset mid-operation: with count=2, drive reset=0 between clock edges -> out_valid=0 and count=0 before the next rising edge.
